// File: rtl/axi_mem_responder.sv
// AXI3 slave that terminates the PS GP master port into an on-chip scratch RAM.
// Latency: AW->wready next cycle, last W->bvalid next cycle; AR->first R beat next cycle, then 1 beat/cycle.
// Backpressure: one burst in flight per direction; B waits for bready, R beats hold while rready is low.
module axi_mem_responder #(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_BITS  = 64,
   parameter int ID_BITS    = 6,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   // write address channel
   input  logic                   axi_mem_awvalid,
   input  logic [ID_BITS-1:0]     axi_mem_awid,
   input  logic [ADDR_BITS-1:0]   axi_mem_awaddr,
   input  logic [3:0]             axi_mem_awlen,
   input  logic [2:0]             axi_mem_awsize,
   input  logic [1:0]             axi_mem_awburst,
   input  logic                   axi_mem_awlock,
   input  logic [3:0]             axi_mem_awcache,
   input  logic [2:0]             axi_mem_awprot,
   input  logic [3:0]             axi_mem_awqos,
   output logic                   axi_mem_awready,
   // write data channel
   input  logic                   axi_mem_wvalid,
   input  logic [ID_BITS-1:0]     axi_mem_wid,
   input  logic [DATA_BITS-1:0]   axi_mem_wdata,
   input  logic [DATA_BITS/8-1:0] axi_mem_wstrb,
   input  logic                   axi_mem_wlast,
   output logic                   axi_mem_wready,
   // write response channel
   output logic                   axi_mem_bvalid,
   output logic [ID_BITS-1:0]     axi_mem_bid,
   output logic [1:0]             axi_mem_bresp,
   input  logic                   axi_mem_bready,
   // read address channel
   input  logic                   axi_mem_arvalid,
   input  logic [ID_BITS-1:0]     axi_mem_arid,
   input  logic [ADDR_BITS-1:0]   axi_mem_araddr,
   input  logic [3:0]             axi_mem_arlen,
   input  logic [2:0]             axi_mem_arsize,
   input  logic [1:0]             axi_mem_arburst,
   input  logic                   axi_mem_arlock,
   input  logic [3:0]             axi_mem_arcache,
   input  logic [2:0]             axi_mem_arprot,
   input  logic [3:0]             axi_mem_arqos,
   output logic                   axi_mem_arready,
   // read data channel
   output logic                   axi_mem_rvalid,
   output logic [ID_BITS-1:0]     axi_mem_rid,
   output logic [DATA_BITS-1:0]   axi_mem_rdata,
   output logic [1:0]             axi_mem_rresp,
   output logic                   axi_mem_rlast,
   input  logic                   axi_mem_rready
);

   localparam int         DEPTH       = 1 << DEPTH_LOG2;
   localparam int         STRB_BITS   = DATA_BITS / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   // Scratch storage; deliberately not reset.
   logic [DATA_BITS-1:0] mem [DEPTH];

   w_state_t              w_state;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [3:0]            w_len;
   logic [3:0]            w_cnt;
   logic                  w_incr;
   logic                  w_ok;
   logic                  w_err;

   r_state_t              r_state;
   logic [DEPTH_LOG2-1:0] r_idx;     // index of the word to load for the next beat
   logic [3:0]            r_len;
   logic [3:0]            r_cnt;
   logic                  r_incr;
   logic                  r_ok;

   logic [DEPTH_LOG2-1:0] aw_idx;
   logic [DEPTH_LOG2-1:0] ar_idx;
   logic                  aw_ok;
   logic                  ar_ok;
   logic                  w_fire;
   logic                  w_last_beat;
   logic                  w_mismatch;

   // Only FIXED and INCR are served; WRAP and reserved run to completion as errors.
   assign aw_idx      = axi_mem_awaddr[DEPTH_LOG2+2:3];
   assign ar_idx      = axi_mem_araddr[DEPTH_LOG2+2:3];
   assign aw_ok       = (axi_mem_awburst == BURST_FIXED) || (axi_mem_awburst == BURST_INCR);
   assign ar_ok       = (axi_mem_arburst == BURST_FIXED) || (axi_mem_arburst == BURST_INCR);
   assign w_fire      = axi_mem_wready && axi_mem_wvalid;
   assign w_last_beat = (w_cnt == w_len);
   assign w_mismatch  = (axi_mem_wlast != w_last_beat);

   // Sideband fields and alias/byte-offset address bits carry no meaning here.
   logic unused_sidebands;
   assign unused_sidebands = ^{axi_mem_awsize, axi_mem_awlock, axi_mem_awcache, axi_mem_awprot,
                               axi_mem_awqos, axi_mem_wid, axi_mem_awaddr,
                               axi_mem_arsize, axi_mem_arlock, axi_mem_arcache, axi_mem_arprot,
                               axi_mem_arqos, axi_mem_araddr};

   // Commit the strobed bytes of every accepted beat of a supported write burst.
   always_ff @(posedge clock) begin
      if (w_fire && w_ok) begin
         for (int i = 0; i < STRB_BITS; i++) begin
            if (axi_mem_wstrb[i]) mem[w_idx][8*i +: 8] <= axi_mem_wdata[8*i +: 8];
         end
      end
   end

   // Write FSM: address, data beats counted against len, then a single response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state         <= W_IDLE;
         axi_mem_awready <= 1'b1;
         axi_mem_wready  <= 1'b0;
         axi_mem_bvalid  <= 1'b0;
         axi_mem_bid     <= '0;
         axi_mem_bresp   <= RESP_OKAY;
         w_idx           <= '0;
         w_len           <= '0;
         w_cnt           <= '0;
         w_incr          <= 1'b0;
         w_ok            <= 1'b0;
         w_err           <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (axi_mem_awvalid) begin
                  w_idx           <= aw_idx;
                  w_len           <= axi_mem_awlen;
                  w_cnt           <= '0;
                  w_incr          <= (axi_mem_awburst == BURST_INCR);
                  w_ok            <= aw_ok;
                  w_err           <= 1'b0;
                  axi_mem_bid     <= axi_mem_awid;
                  axi_mem_awready <= 1'b0;
                  axi_mem_wready  <= 1'b1;
                  w_state         <= W_DATA;
               end
            end
            W_DATA: begin
               if (axi_mem_wvalid) begin
                  if (w_incr) w_idx <= w_idx + 1'b1;
                  w_cnt <= w_cnt + 4'd1;
                  if (w_last_beat) begin
                     axi_mem_wready <= 1'b0;
                     axi_mem_bvalid <= 1'b1;
                     axi_mem_bresp  <= (!w_ok || w_err || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
                     w_state        <= W_RESP;
                  end else begin
                     w_err <= w_err | w_mismatch;
                  end
               end
            end
            W_RESP: begin
               if (axi_mem_bready) begin
                  axi_mem_bvalid  <= 1'b0;
                  axi_mem_awready <= 1'b1;
                  w_state         <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: rdata is preloaded on AR and reloaded on each non-final R handshake.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= R_IDLE;
         axi_mem_arready <= 1'b1;
         axi_mem_rvalid  <= 1'b0;
         axi_mem_rlast   <= 1'b0;
         axi_mem_rid     <= '0;
         axi_mem_rresp   <= RESP_OKAY;
         axi_mem_rdata   <= '0;
         r_idx           <= '0;
         r_len           <= '0;
         r_cnt           <= '0;
         r_incr          <= 1'b0;
         r_ok            <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axi_mem_arvalid) begin
                  axi_mem_rid     <= axi_mem_arid;
                  axi_mem_rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                  axi_mem_rdata   <= ar_ok ? mem[ar_idx] : '0;
                  axi_mem_rlast   <= (axi_mem_arlen == 4'd0);
                  axi_mem_rvalid  <= 1'b1;
                  axi_mem_arready <= 1'b0;
                  r_idx           <= (axi_mem_arburst == BURST_INCR) ? ar_idx + 1'b1 : ar_idx;
                  r_len           <= axi_mem_arlen;
                  r_cnt           <= '0;
                  r_incr          <= (axi_mem_arburst == BURST_INCR);
                  r_ok            <= ar_ok;
                  r_state         <= R_DATA;
               end
            end
            R_DATA: begin
               if (axi_mem_rready) begin
                  if (axi_mem_rlast) begin
                     axi_mem_rvalid  <= 1'b0;
                     axi_mem_rlast   <= 1'b0;
                     axi_mem_arready <= 1'b1;
                     r_state         <= R_IDLE;
                  end else begin
                     axi_mem_rdata <= r_ok ? mem[r_idx] : '0;
                     axi_mem_rlast <= ((r_cnt + 4'd1) == r_len);
                     r_cnt         <= r_cnt + 4'd1;
                     if (r_incr) r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: randomized AXI traffic checked against a word-array reference model.
// Reads in overlapping traffic are predicted from write commit edges versus read sample edges.
`timescale 1ns/1ps
module tb_axi_mem_responder;
   localparam int DEPTH = 1024;

   logic clk, rst_n;
   logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
   logic arvalid, arready, arlock, rvalid, rready, rlast;
   logic [5:0] awid, wid, bid, arid, rid;
   logic [31:0] awaddr, araddr;
   logic [3:0] awlen, awcache, awqos, arlen, arcache, arqos;
   logic [2:0] awsize, awprot, arsize, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic [63:0] wdata, rdata;
   logic [7:0] wstrb;

   int total = 0;
   int bad = 0;
   int edge_no = 0;

   logic [63:0] model[DEPTH];
   logic [63:0] snap[DEPTH];
   logic [63:0] exp_dat[16];
   logic [63:0] wdat[16];
   logic [7:0]  wstb[16];
   logic        wlst[16];
   int          wr_edge[16];
   int          aw_edge, b_edge;
   logic [1:0]  aw_after, w_after;
   logic        b_after, ar_after;
   logic [63:0] rd_dat[16];
   logic [1:0]  rd_resp[16];
   logic        rd_last[16];
   logic [5:0]  rd_id[16];
   int          rd_load[16];
   int          rd_hs[16];
   int          rd_lat, rd_unstable;

   axi_mem_responder dut (
      .clock(clk), .reset(rst_n),
      .axi_mem_awvalid(awvalid), .axi_mem_awid(awid), .axi_mem_awaddr(awaddr), .axi_mem_awlen(awlen),
      .axi_mem_awsize(awsize), .axi_mem_awburst(awburst), .axi_mem_awlock(awlock), .axi_mem_awcache(awcache),
      .axi_mem_awprot(awprot), .axi_mem_awqos(awqos), .axi_mem_awready(awready),
      .axi_mem_wvalid(wvalid), .axi_mem_wid(wid), .axi_mem_wdata(wdata), .axi_mem_wstrb(wstrb),
      .axi_mem_wlast(wlast), .axi_mem_wready(wready),
      .axi_mem_bvalid(bvalid), .axi_mem_bid(bid), .axi_mem_bresp(bresp), .axi_mem_bready(bready),
      .axi_mem_arvalid(arvalid), .axi_mem_arid(arid), .axi_mem_araddr(araddr), .axi_mem_arlen(arlen),
      .axi_mem_arsize(arsize), .axi_mem_arburst(arburst), .axi_mem_arlock(arlock), .axi_mem_arcache(arcache),
      .axi_mem_arprot(arprot), .axi_mem_arqos(arqos), .axi_mem_arready(arready),
      .axi_mem_rvalid(rvalid), .axi_mem_rid(rid), .axi_mem_rdata(rdata), .axi_mem_rresp(rresp),
      .axi_mem_rlast(rlast), .axi_mem_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_no <= edge_no + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference addressing: word = addr[12:3]; INCR steps by one word modulo depth, FIXED stays.
   function automatic int widx(input logic [31:0] addr);
      return int'(addr[12:3]);
   endfunction

   function automatic int next_idx(input int idx, input logic [1:0] burst);
      return (burst == 2'b01) ? (idx + 1) % DEPTH : idx;
   endfunction

   function automatic bit supported(input logic [1:0] burst);
      return (burst == 2'b00) || (burst == 2'b01);
   endfunction

   function automatic logic [1:0] exp_bresp(input logic [1:0] burst, input int len);
      if (!supported(burst)) return 2'b10;
      for (int b = 0; b <= len; b++) if (wlst[b] != (b == len)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [1:0] burst, input int len);
      int idx;
      idx = widx(addr);
      if (supported(burst)) begin
         for (int b = 0; b <= len; b++) begin
            for (int k = 0; k < 8; k++) if (wstb[b][k]) model[idx][8*k +: 8] = wdat[b][8*k +: 8];
            idx = next_idx(idx, burst);
         end
      end
   endtask

   task automatic exp_read(input logic [31:0] addr, input logic [1:0] burst, input int len);
      int idx;
      idx = widx(addr);
      for (int b = 0; b <= len; b++) begin
         exp_dat[b] = supported(burst) ? model[idx] : 64'd0;
         idx = next_idx(idx, burst);
      end
   endtask

   task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [1:0] burst,
                           input int len, input bit gaps,
                           output logic [5:0] got_id, output logic [1:0] got_resp, output bit tmo);
      int n;
      tmo = 0; got_id = 'x; got_resp = 'x;
      awid = id; awaddr = addr; awburst = burst; awlen = len[3:0]; awsize = 3'd3; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin step(); n++; end
      if (!awready) begin tmo = 1; awvalid = 1'b0; return; end
      aw_edge = edge_no + 1;
      step();
      awvalid = 1'b0;
      aw_after = {awready, wready};
      for (int b = 0; b <= len; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin wvalid = 1'b0; step(); end
         wvalid = 1'b1; wid = id; wdata = wdat[b]; wstrb = wstb[b]; wlast = wlst[b];
         n = 0;
         while (!wready && n < 100) begin step(); n++; end
         if (!wready) begin tmo = 1; wvalid = 1'b0; return; end
         wr_edge[b] = edge_no + 1;
         step();
      end
      wvalid = 1'b0;
      w_after = {wready, bvalid};
      if (gaps) begin bready = 1'b0; repeat ($urandom_range(0, 2)) step(); end
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 100) begin step(); n++; end
      if (!bvalid) begin tmo = 1; bready = 1'b0; return; end
      got_id = bid; got_resp = bresp; b_edge = edge_no + 1;
      step();
      bready = 1'b0;
      b_after = awready;
   endtask

   // mode 0: rready always high, 1: rready every other cycle, 2: random rready
   task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [1:0] burst,
                          input int len, input int mode, output bit tmo);
      int n, beat, cyc;
      bit stalled;
      logic [63:0] hd;
      logic hl;
      logic [5:0] hi;
      tmo = 0; rd_unstable = 0; rd_lat = -1; stalled = 0; hd = '0; hl = 1'b0; hi = '0;
      arid = id; araddr = addr; arburst = burst; arlen = len[3:0]; arsize = 3'd3; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin step(); n++; end
      if (!arready) begin tmo = 1; arvalid = 1'b0; return; end
      rd_load[0] = edge_no + 1;
      step();
      arvalid = 1'b0;
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 300) begin
         rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         if (rvalid && rd_lat < 0) rd_lat = cyc;
         if (rvalid) begin
            if (stalled && (rdata !== hd || rlast !== hl || rid !== hi)) rd_unstable++;
            if (rready) begin
               rd_dat[beat] = rdata; rd_resp[beat] = rresp; rd_last[beat] = rlast; rd_id[beat] = rid;
               rd_hs[beat] = edge_no + 1;
               if (beat < 15) rd_load[beat+1] = edge_no + 1;
               beat++; stalled = 0;
            end else begin
               stalled = 1; hd = rdata; hl = rlast; hi = rid;
            end
         end
         step();
         cyc++;
      end
      rready = 1'b0;
      if (beat <= len) begin tmo = 1; return; end
      ar_after = arready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      total++;
      if (awready !== 1'b1 || arready !== 1'b1) begin bad++; $display("FAIL reset_ready: got aw=%b ar=%b want 1 1", awready, arready); end
      total++;
      if ({wready, bvalid, rvalid, rlast} !== 4'b0000) begin bad++; $display("FAIL reset_valids: got w/b/r/last=%b want 0000", {wready, bvalid, rvalid, rlast}); end
      total++;
      if (bresp !== 2'd0 || rresp !== 2'd0 || bid !== 6'd0 || rid !== 6'd0 || rdata !== 64'd0) begin
         bad++; $display("FAIL reset_fields: got bresp=%0d rresp=%0d bid=%0d rid=%0d rdata=%h want all 0", bresp, rresp, bid, rid, rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin bad++; $display("FAIL post_reset: got aw=%b ar=%b w=%b want 1 1 0", awready, arready, wready); end
   endtask

   // Fill the whole RAM so every later read has a defined expectation.
   task automatic test_fill();
      logic [5:0] gi; logic [1:0] gr; bit tmo;
      int errs;
      errs = 0;
      for (int blk = 0; blk < DEPTH / 16; blk++) begin
         for (int b = 0; b < 16; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; wlst[b] = (b == 15); end
         do_write(6'(blk), 32'(blk * 128), 2'b01, 15, 1'b1, gi, gr, tmo);
         total++;
         if (tmo || gi !== 6'(blk) || gr !== 2'b00) begin bad++; $display("FAIL fill_blk%0d: got tmo=%0d bid=%0d bresp=%0d want 0 %0d 0", blk, tmo, gi, gr, blk); end
         model_write(32'(blk * 128), 2'b01, 15);
      end
   endtask

   task automatic test_single();
      logic [5:0] gi; logic [1:0] gr; bit tmo;
      wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF; wlst[0] = 1'b1;
      do_write(6'd5, 32'h40, 2'b01, 0, 1'b0, gi, gr, tmo);
      total++;
      if (tmo || gi !== 6'd5 || gr !== 2'b00) begin bad++; $display("FAIL single_b: got tmo=%0d bid=%0d bresp=%0d want 0 5 0", tmo, gi, gr); end
      total++;
      if (aw_after !== 2'b01 || w_after !== 2'b01 || b_after !== 1'b1) begin
         bad++; $display("FAIL single_wr_timing: got aw/w=%b w/b=%b aw_after_b=%b want 01 01 1", aw_after, w_after, b_after);
      end
      total++;
      if (b_edge - aw_edge !== 2) begin bad++; $display("FAIL single_wr_cycles: got %0d edges AW->B want 2", b_edge - aw_edge); end
      model_write(32'h40, 2'b01, 0);
      do_read(6'd5, 32'h40, 2'b01, 0, 0, tmo);
      total++;
      if (tmo || rd_dat[0] !== 64'h1122334455667788 || rd_id[0] !== 6'd5 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
         bad++; $display("FAIL single_rd: got tmo=%0d data=%h rid=%0d rlast=%b rresp=%0d want 0 1122334455667788 5 1 0", tmo, rd_dat[0], rd_id[0], rd_last[0], rd_resp[0]);
      end
      total++;
      if (rd_lat !== 0 || ar_after !== 1'b1) begin bad++; $display("FAIL single_rd_timing: got first-beat wait=%0d arready_after=%b want 0 1", rd_lat, ar_after); end
   endtask

   task automatic test_burst_strobe();
      logic [5:0] gi; logic [1:0] gr; bit tmo;
      for (int b = 0; b < 16; b++) begin wdat[b] = 64'(b); wstb[b] = (b % 2 == 1) ? 8'h0F : 8'hFF; wlst[b] = (b == 15); end
      do_write(6'd9, 32'h100, 2'b01, 15, 1'b0, gi, gr, tmo);
      total++;
      if (tmo || gi !== 6'd9 || gr !== 2'b00) begin bad++; $display("FAIL burst_b: got tmo=%0d bid=%0d bresp=%0d want 0 9 0", tmo, gi, gr); end
      snap = model;
      model_write(32'h100, 2'b01, 15);
      exp_read(32'h100, 2'b01, 15);
      do_read(6'd12, 32'h100, 2'b01, 15, 1, tmo);
      total++;
      if (tmo || rd_unstable !== 0) begin bad++; $display("FAIL burst_rd_stall: got tmo=%0d unstable=%0d want 0 0", tmo, rd_unstable); end
      for (int b = 0; b <= 15; b++) begin
         total++;
         if (rd_dat[b] !== exp_dat[b] || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 15) || rd_id[b] !== 6'd12) begin
            bad++; $display("FAIL burst_rd beat %0d: got data=%h resp=%0d last=%b id=%0d want %h 0 %b 12", b, rd_dat[b], rd_resp[b], rd_last[b], rd_id[b], exp_dat[b], (b == 15));
         end
      end
      total++;
      if (rd_dat[3][63:32] !== snap[widx(32'h100) + 3][63:32] || rd_dat[3][31:0] !== 32'd3) begin
         bad++; $display("FAIL burst_odd_upper: got %h want upper %h lower 3", rd_dat[3], snap[widx(32'h100) + 3][63:32]);
      end
   endtask

   task automatic test_fixed_wrap();
      logic [5:0] gi; logic [1:0] gr; bit tmo;
      for (int b = 0; b < 4; b++) begin wdat[b] = 64'(b + 1); wstb[b] = 8'hFF; wlst[b] = (b == 3); end
      do_write(6'd1, 32'h200, 2'b00, 3, 1'b0, gi, gr, tmo);
      total++;
      if (tmo || gr !== 2'b00) begin bad++; $display("FAIL fixed_b: got tmo=%0d bresp=%0d want 0 0", tmo, gr); end
      model_write(32'h200, 2'b00, 3);
      do_read(6'd2, 32'h200, 2'b01, 0, 0, tmo);
      total++;
      if (tmo || rd_dat[0] !== 64'd4) begin bad++; $display("FAIL fixed_rd: got tmo=%0d data=%h want 4", tmo, rd_dat[0]); end
      for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; wlst[b] = (b == 3); end
      do_write(6'd3, 32'h200, 2'b10, 3, 1'b0, gi, gr, tmo);
      total++;
      if (tmo || gi !== 6'd3 || gr !== 2'b10) begin bad++; $display("FAIL wrap_b: got tmo=%0d bid=%0d bresp=%0d want 0 3 2", tmo, gi, gr); end
      do_read(6'd4, 32'h200, 2'b01, 0, 0, tmo);
      total++;
      if (tmo || rd_dat[0] !== 64'd4) begin bad++; $display("FAIL wrap_unchanged: got tmo=%0d data=%h want 4", tmo, rd_dat[0]); end
      do_read(6'd6, 32'h200, 2'b10, 3, 0, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL wrap_rd_tmo: got timeout want completion"); end
      for (int b = 0; b < 4; b++) begin
         total++;
         if (rd_dat[b] !== 64'd0 || rd_resp[b] !== 2'b10 || rd_last[b] !== (b == 3) || rd_id[b] !== 6'd6) begin
            bad++; $display("FAIL wrap_rd beat %0d: got data=%h resp=%0d last=%b id=%0d want 0 2 %b 6", b, rd_dat[b], rd_resp[b], rd_last[b], rd_id[b], (b == 3));
         end
      end
   endtask

   task automatic test_wlast_mismatch();
      logic [5:0] gi; logic [1:0] gr; bit tmo;
      for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; wlst[b] = (b == 1); end
      do_write(6'd7, 32'h280, 2'b01, 3, 1'b0, gi, gr, tmo);
      total++;
      if (tmo || gi !== 6'd7 || gr !== 2'b10) begin bad++; $display("FAIL wlast_b: got tmo=%0d bid=%0d bresp=%0d want 0 7 2", tmo, gi, gr); end
      total++;
      if (wr_edge[3] - wr_edge[0] !== 3) begin bad++; $display("FAIL wlast_beats: got span %0d want 3", wr_edge[3] - wr_edge[0]); end
      model_write(32'h280, 2'b01, 3);
      exp_read(32'h280, 2'b01, 3);
      do_read(6'd8, 32'h280, 2'b01, 3, 2, tmo);
      for (int b = 0; b < 4; b++) begin
         total++;
         if (tmo || rd_dat[b] !== exp_dat[b]) begin bad++; $display("FAIL wlast_data beat %0d: got tmo=%0d data=%h want %h", b, tmo, rd_dat[b], exp_dat[b]); end
      end
   endtask

   // Overlapping read (words base..base+7) and write (words base+1..base+8) started together.
   task automatic test_concurrent(input bit randomized);
      logic [5:0] gi; logic [1:0] gr; bit wtmo, rtmo;
      int rb, wb;
      rb = widx(32'h300); wb = widx(32'h308);
      snap = model;
      for (int b = 0; b < 8; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'($urandom); wlst[b] = (b == 7); end
      fork
         do_write(6'd20, 32'h308, 2'b01, 7, randomized, gi, gr, wtmo);
         do_read(6'd21, 32'h300, 2'b01, 7, randomized ? 2 : 0, rtmo);
      join
      total++;
      if (wtmo || rtmo || gr !== 2'b00 || gi !== 6'd20) begin bad++; $display("FAIL conc_done: got wtmo=%0d rtmo=%0d bresp=%0d bid=%0d want 0 0 0 20", wtmo, rtmo, gr, gi); end
      if (!randomized) begin
         total++;
         if (wr_edge[7] - wr_edge[0] !== 7 || rd_hs[7] - rd_hs[0] !== 7) begin
            bad++; $display("FAIL conc_rate: got w span=%0d r span=%0d want 7 7", wr_edge[7] - wr_edge[0], rd_hs[7] - rd_hs[0]);
         end
      end
      // A read sees a write only if the write committed on an earlier edge than the read sampled.
      for (int b = 0; b < 8; b++) begin
         int w;
         logic [63:0] v;
         w = (rb + b) % DEPTH;
         v = snap[w];
         for (int i = 0; i < 8; i++)
            if ((wb + i) % DEPTH == w && wr_edge[i] < rd_load[b])
               for (int k = 0; k < 8; k++) if (wstb[i][k]) v[8*k +: 8] = wdat[i][8*k +: 8];
         total++;
         if (rd_dat[b] !== v || rd_last[b] !== (b == 7)) begin
            bad++; $display("FAIL conc_rd beat %0d: got data=%h last=%b want %h %b", b, rd_dat[b], rd_last[b], v, (b == 7));
         end
      end
      model_write(32'h308, 2'b01, 7);
   endtask

   task automatic test_random();
      logic [5:0] gi, id; logic [1:0] gr, burst; bit tmo;
      logic [31:0] addr;
      int len, f;
      for (int it = 0; it < 25; it++) begin
         burst = ($urandom_range(0, 5) < 3) ? 2'b01 : 2'($urandom);
         len = $urandom_range(0, 15); addr = $urandom; id = 6'($urandom);
         for (int b = 0; b < 16; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'($urandom); wlst[b] = (b == len); end
         if ($urandom_range(0, 5) == 0) begin f = $urandom_range(0, len); wlst[f] = ~wlst[f]; end
         do_write(id, addr, burst, len, 1'b1, gi, gr, tmo);
         total++;
         if (tmo || gi !== id || gr !== exp_bresp(burst, len)) begin
            bad++; $display("FAIL rand_wr it%0d: got tmo=%0d bid=%0d bresp=%0d want 0 %0d %0d", it, tmo, gi, gr, id, exp_bresp(burst, len));
         end
         model_write(addr, burst, len);
         if ($urandom_range(0, 1) == 0) addr = $urandom;
         burst = ($urandom_range(0, 5) < 3) ? 2'b01 : 2'($urandom);
         len = $urandom_range(0, 15); id = 6'($urandom);
         exp_read(addr, burst, len);
         do_read(id, addr, burst, len, 2, tmo);
         total++;
         if (tmo || rd_unstable !== 0) begin bad++; $display("FAIL rand_rd_flow it%0d: got tmo=%0d unstable=%0d want 0 0", it, tmo, rd_unstable); end
         for (int b = 0; b <= len; b++) begin
            total++;
            if (rd_dat[b] !== exp_dat[b] || rd_resp[b] !== (supported(burst) ? 2'b00 : 2'b10) || rd_last[b] !== (b == len) || rd_id[b] !== id) begin
               bad++; $display("FAIL rand_rd it%0d beat %0d: got data=%h resp=%0d last=%b id=%0d want %h %0d %b %0d", it, b, rd_dat[b], rd_resp[b], rd_last[b], rd_id[b],
                               exp_dat[b], supported(burst) ? 2'b00 : 2'b10, (b == len), id);
            end
         end
      end
   endtask

   task automatic test_reset_midburst();
      bit tmo;
      int n, got;
      // Write: three beats of an 8-beat burst land, then reset.
      for (int b = 0; b < 8; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; wlst[b] = (b == 7); end
      awid = 6'd30; awaddr = 32'h380; awburst = 2'b01; awlen = 4'd7; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin step(); n++; end
      step();
      awvalid = 1'b0;
      got = 0; n = 0;
      while (got < 3 && n < 100) begin
         wvalid = 1'b1; wdata = wdat[got]; wstrb = wstb[got]; wlast = 1'b0;
         if (wready) got++;
         step(); n++;
      end
      wvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (got !== 3 || wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
         bad++; $display("FAIL rst_wr: got beats=%0d wready=%b bvalid=%b awready=%b want 3 0 0 1", got, wready, bvalid, awready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      model_write(32'h380, 2'b01, 2);
      // Read: reset while beat 5 of a 16-beat burst is presented.
      arid = 6'd31; araddr = 32'h100; arburst = 2'b01; arlen = 4'd15; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin step(); n++; end
      step();
      arvalid = 1'b0; rready = 1'b1;
      got = 0; n = 0;
      while (got < 5 && n < 100) begin if (rvalid) got++; step(); n++; end
      total++;
      if (got !== 5 || rvalid !== 1'b1) begin bad++; $display("FAIL rst_rd_pre: got beats=%0d rvalid=%b want 5 1", got, rvalid); end
      rst_n = 1'b0;
      rready = 1'b0;
      #1;
      total++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL rst_rd: got rvalid=%b rlast=%b arready=%b want 0 0 1", rvalid, rlast, arready); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL rst_release: got arready=%b awready=%b rvalid=%b want 1 1 0", arready, awready, rvalid); end
      exp_read(32'h380, 2'b01, 7);
      do_read(6'd32, 32'h380, 2'b01, 7, 2, tmo);
      for (int b = 0; b < 8; b++) begin
         total++;
         if (tmo || rd_dat[b] !== exp_dat[b] || rd_last[b] !== (b == 7)) begin
            bad++; $display("FAIL rst_after_rd beat %0d: got tmo=%0d data=%h last=%b want %h %b", b, tmo, rd_dat[b], rd_last[b], exp_dat[b], (b == 7));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01;
      awlock = 1'b0; awcache = '0; awprot = '0; awqos = '0;
      wvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
      arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01;
      arlock = 1'b0; arcache = '0; arprot = '0; arqos = '0; rready = 1'b0;
      test_reset();
      test_fill();
      test_single();
      test_burst_strobe();
      test_fixed_wrap();
      test_wlast_mismatch();
      test_concurrent(1'b0);
      test_concurrent(1'b1);
      test_random();
      test_reset_midburst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
